// File: rtl/lbp_gray_host.sv
// Image/result store and host sequencer for the LBP engine: load, serve, dump.
// Optional gray_req-to-finish cycle counter enabled by LBP_GRAY_HOST_PERF_EN.
module lbp_gray_host #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   output logic          gray_ready,
   input  logic          gray_req,
   input  logic [AW-1:0] gray_addr,
   output logic [DW-1:0] gray_data,
   input  logic          lbp_valid,
   input  logic [AW-1:0] lbp_addr,
   input  logic [DW-1:0] lbp_data,
   input  logic          finish,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          done,
   output logic          err_addr,
   output logic [AW-1:0] wr_count,
   output logic [31:0]   perf_cycles
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = AW - CW;
   localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_SERVE = 2'd1,
      S_DUMP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          load_ready_q, load_ready_d;
   logic          gray_ready_q, gray_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic          done_q, done_d;
   logic          err_addr_q, err_addr_d;
   logic [AW-1:0] wr_count_q, wr_count_d;

   logic [DW-1:0] img_mem [NPIX];
   logic [DW-1:0] res_mem [NPIX];

   logic img_we;
   logic res_we;
   logic load_last;

   function automatic logic is_border(input logic [AW-1:0] a);
      logic [RW-1:0] row;
      logic [CW-1:0] col;
      row = a[AW-1:CW];
      col = a[CW-1:0];
      return (row == '0) || (row == RW'(IMG_H - 1)) ||
             (col == '0) || (col == CW'(IMG_W - 1));
   endfunction

   assign img_we    = (state_q == S_LOAD) && load_valid && load_ready_q;
   assign res_we    = (state_q == S_SERVE) && lbp_valid;
   assign load_last = img_we && (ptr_q == LAST);

   // Storage arrays carry no reset; only the sequencing state does.
   always_ff @(posedge clk) begin
      if (img_we) begin
         img_mem[ptr_q] <= load_data;
      end
      if (res_we) begin
         res_mem[lbp_addr] <= lbp_data;
      end
   end

   assign gray_data = img_mem[gray_addr];
   assign out_data  = is_border(out_addr_q) ? '0 : res_mem[out_addr_q];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      load_ready_d = load_ready_q;
      gray_ready_d = gray_ready_q;
      out_valid_d  = out_valid_q;
      out_addr_d   = out_addr_q;
      done_d       = done_q;
      err_addr_d   = err_addr_q;
      wr_count_d   = wr_count_q;
      unique case (state_q)
         S_LOAD: begin
            if (img_we) begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST) begin
                  load_ready_d = 1'b0;
                  gray_ready_d = 1'b1;
                  state_d      = S_SERVE;
               end
            end
         end
         S_SERVE: begin
            // A write in the finish cycle lands before the transition.
            if (lbp_valid) begin
               if (wr_count_q != '1) begin
                  wr_count_d = wr_count_q + 1'b1;
               end
               if (is_border(lbp_addr)) begin
                  err_addr_d = 1'b1;
               end
            end
            if (finish) begin
               gray_ready_d = 1'b0;
               out_valid_d  = 1'b1;
               out_addr_d   = '0;
               state_d      = S_DUMP;
            end
         end
         S_DUMP: begin
            if (out_valid_q && out_ready) begin
               out_addr_d = out_addr_q + 1'b1;
               if (out_addr_q == LAST) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_LOAD;
         ptr_q        <= '0;
         load_ready_q <= 1'b1;
         gray_ready_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         done_q       <= 1'b0;
         err_addr_q   <= 1'b0;
         wr_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         load_ready_q <= load_ready_d;
         gray_ready_q <= gray_ready_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         done_q       <= done_d;
         err_addr_q   <= err_addr_d;
         wr_count_q   <= wr_count_d;
      end
   end

`ifdef LBP_GRAY_HOST_PERF_EN
   logic [31:0] perf_q, perf_d;
   logic        perf_on_q, perf_on_d;

   // Counting starts at the first gray_req and stops once SERVE is left.
   always_comb begin
      perf_d    = perf_q;
      perf_on_d = perf_on_q;
      if (load_last) begin
         perf_d    = '0;
         perf_on_d = 1'b0;
      end else if ((state_q == S_SERVE) && (gray_req || perf_on_q)) begin
         perf_on_d = 1'b1;
         if (perf_q != '1) begin
            perf_d = perf_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_q    <= '0;
         perf_on_q <= 1'b0;
      end else begin
         perf_q    <= perf_d;
         perf_on_q <= perf_on_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   logic unused_gray_req;
   assign unused_gray_req = gray_req;
   assign perf_cycles     = '0;
`endif

   assign load_ready = load_ready_q;
   assign gray_ready = gray_ready_q;
   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign done       = done_q;
   assign err_addr   = err_addr_q;
   assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_lbp_gray_host.sv
// Directed bench for lbp_gray_host: load, serve, dump, stall, resets.
// Expects perf_cycles=1001 when LBP_GRAY_HOST_PERF_EN is defined, else 0.
module tb_lbp_gray_host;

   localparam int AW = 14;
   localparam int DW = 8;
   localparam int NPIX = 16384;
`ifdef LBP_GRAY_HOST_PERF_EN
   localparam logic [31:0] PERF_EXP = 32'd1001;
`else
   localparam logic [31:0] PERF_EXP = 32'd0;
`endif

   logic          clk;
   logic          reset;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [DW-1:0] lbp_data;
   logic          finish;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          done;
   logic          err_addr;
   logic [AW-1:0] wr_count;
   logic [31:0]   perf_cycles;

   int n_chk;
   int n_pass;
   int seq_bad;

   lbp_gray_host dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .gray_ready(gray_ready),
      .gray_req(gray_req), .gray_addr(gray_addr),
      .gray_data(gray_data), .lbp_valid(lbp_valid),
      .lbp_addr(lbp_addr), .lbp_data(lbp_data),
      .finish(finish), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .done(done),
      .err_addr(err_addr), .wr_count(wr_count),
      .perf_cycles(perf_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_image(input bit invert);
      for (int i = 0; i < NPIX; i++) begin
         load_valid = 1'b1;
         load_data  = invert ? ~8'(i) : 8'(i);
         if (i == NPIX - 1) chk("load_ready_last", load_ready, 1);
         @(negedge clk);
      end
      load_valid = 1'b0;
   endtask

   function automatic logic [7:0] exp_out(input int a);
      if (a == 129) return 8'hA5;
      if (a == 130) return 8'h3C;
      if (a == 200) return 8'h5A;
      return 8'h00;
   endfunction

   initial begin
      n_chk = 0; n_pass = 0; seq_bad = 0;
      reset = 1'b0; load_valid = 1'b0; load_data = '0;
      gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0;
      lbp_addr = '0; lbp_data = '0; finish = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_gray_ready", gray_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_addr, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_perf", perf_cycles, 0);
      reset = 1'b1;
      @(negedge clk);

      load_image(1'b0);
      chk("load_ready_drop", load_ready, 0);
      chk("gray_ready_up", gray_ready, 1);
      gray_addr = 14'd129; #1;
      chk("gray_129", gray_data, 8'h81);
      gray_addr = 14'd16383; #1;
      chk("gray_16383", gray_data, 8'hFF);
      gray_addr = 14'd300; #1;
      chk("gray_300", gray_data, 8'h2C);
      repeat (3) @(negedge clk);

      for (int k = 0; k < 1000; k++) begin
         gray_req  = 1'b1;
         lbp_valid = 1'b0;
         if (k == 10) begin
            lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'hA5;
         end
         if (k == 20) begin
            lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'hEE;
         end
         if (k == 30) begin
            lbp_valid = 1'b1; lbp_addr = 14'd200; lbp_data = 8'h5A;
         end
         if (k == 15) begin
            chk("wr_count_1", wr_count, 1);
            chk("err_clean", err_addr, 0);
         end
         if (k == 25) begin
            chk("wr_count_2", wr_count, 2);
            chk("err_border", err_addr, 1);
         end
         if (k == 50) begin
            gray_addr = 14'd1000; #1;
            chk("gray_1000", gray_data, 8'hE8);
         end
         @(negedge clk);
      end
      gray_req  = 1'b0;
      lbp_valid = 1'b1; lbp_addr = 14'd130; lbp_data = 8'h3C;
      finish    = 1'b1;
      @(negedge clk);
      lbp_valid = 1'b0; finish = 1'b0;
      chk("dump_valid", out_valid, 1);
      chk("dump_gray_low", gray_ready, 0);
      chk("dump_addr0", out_addr, 0);
      chk("wr_count_4", wr_count, 4);
      chk("perf", perf_cycles, PERF_EXP);

      out_ready = 1'b1;
      for (int a = 0; a < NPIX; a++) begin
         if (out_addr !== AW'(a) || out_valid !== 1'b1) seq_bad++;
         if (a == 0 || a == 5 || a == 127 || a == 129 || a == 130 ||
             a == 16256 || a == 16383)
            chk($sformatf("out_data_%0d", a), out_data, exp_out(a));
         if (a == 201) chk("adv_201", out_addr, 201);
         if (a == 200) begin
            out_ready = 1'b0;
            for (int s = 0; s < 10; s++) begin
               @(negedge clk);
               chk("stall_valid", out_valid, 1);
               chk("stall_addr", out_addr, 200);
               chk("stall_data", out_data, 8'h5A);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      chk("dump_seq", seq_bad, 0);
      chk("done", done, 1);
      chk("done_valid_low", out_valid, 0);
      chk("err_sticky", err_addr, 1);
      chk("perf_frozen", perf_cycles, PERF_EXP);
      lbp_valid = 1'b1; lbp_addr = 14'd300; finish = 1'b1;
      @(negedge clk);
      lbp_valid = 1'b0; finish = 1'b0;
      chk("done_ignore_wr", wr_count, 4);
      chk("done_hold", done, 1);

      reset = 1'b0; #1;
      chk("rst2_done", done, 0);
      chk("rst2_err", err_addr, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50; i++) begin
         load_valid = 1'b1; load_data = 8'h77;
         @(negedge clk);
      end
      load_valid = 1'b0;
      reset = 1'b0; #1;
      chk("midload_ready", load_ready, 1);
      chk("midload_gray", gray_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      load_image(1'b1);
      gray_addr = 14'd0; #1;
      chk("reload_0", gray_data, 8'hFF);
      gray_addr = 14'd129; #1;
      chk("reload_129", gray_data, 8'h7E);
      gray_addr = 14'd49; #1;
      chk("reload_49", gray_data, 8'hCE);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0; out_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("dump2_addr", out_addr, 5);
      reset = 1'b0; #1;
      chk("middump_valid", out_valid, 0);
      chk("middump_gray", gray_ready, 0);
      chk("middump_load", load_ready, 1);
      chk("middump_addr", out_addr, 0);
      chk("middump_wr", wr_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
